// File: rtl/mipi_pkt_parser.sv
// -----------------------------------------------------------------------------
// mipi_pkt_parser
//
// Parses the CSI-2 packet stream delivered by the two-lane byte aligner as
// 16-bit words. Decodes the packet header (DI, WC, ECC), emits frame/line sync
// pulses for short packets, streams long-packet payload words, captures the
// trailing CRC word, and pulses packet_done so the aligner drops word_vld
// between packets. Every output is registered.
//
// Ports
//   sclk           in   byte clock, shared with the aligner
//   s_rst_n        in   asynchronous active-low reset
//   word_data[15:0] in  aligned word, low byte is the earlier stream byte
//   word_vld       in   word_data valid; held high until packet_done is seen
//   invalid_start  in   aligner start-skew error pulse (aborts a packet)
//   packet_done    out  one-cycle pulse at end of packet (normal or abort)
//   hdr_vld        out  one-cycle pulse, pkt_* fields updated
//   pkt_vc[1:0]    out  virtual channel, DI[7:6]
//   pkt_dt[5:0]    out  data type, DI[5:0]
//   pkt_wc[15:0]   out  word count in bytes
//   pkt_ecc[7:0]   out  header ECC byte (passed through, not checked)
//   frame_start    out  pulse for DT 0x00
//   frame_end      out  pulse for DT 0x01
//   line_start     out  pulse for DT 0x02
//   line_end       out  pulse for DT 0x03
//   pix_data[15:0] out  payload word
//   pix_vld        out  pix_data valid
//   pix_last       out  with pix_vld, final payload word of the packet
//   crc_data[15:0] out  received packet CRC, held until the next one arrives
//   pkt_err        out  one-cycle pulse on oversized WC or on abort
// -----------------------------------------------------------------------------
module mipi_pkt_parser #(
    parameter logic [15:0] MAX_WC = 16'd8192
) (
    input  logic        sclk,
    input  logic        s_rst_n,
    input  logic [15:0] word_data,
    input  logic        word_vld,
    input  logic        invalid_start,
    output logic        packet_done,
    output logic        hdr_vld,
    output logic [1:0]  pkt_vc,
    output logic [5:0]  pkt_dt,
    output logic [15:0] pkt_wc,
    output logic [7:0]  pkt_ecc,
    output logic        frame_start,
    output logic        frame_end,
    output logic        line_start,
    output logic        line_end,
    output logic [15:0] pix_data,
    output logic        pix_vld,
    output logic        pix_last,
    output logic [15:0] crc_data,
    output logic        pkt_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR1,
        S_PAYLOAD,
        S_CRC,
        S_WAIT_LOW
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [7:0]  r_di;       // data identifier from header word 0
    logic [7:0]  r_wc_lo;    // WC[7:0] from header word 0
    logic [14:0] r_cnt;      // payload words still to receive

    // Header fields as seen while header word 1 is on the bus.
    logic [15:0] w_wc;
    logic        w_short;
    logic        w_oversize;
    logic [14:0] w_nwords;

    assign w_wc       = {word_data[7:0], r_wc_lo};
    assign w_short    = (r_di[5:4] == 2'b00);          // DT < 0x10
    assign w_oversize = (w_wc > MAX_WC);
    // ceil(WC/2) without the +1 carry: WC[15:1] + WC[0]. Only WC = 0xFFFF
    // would need a 16th bit, and that value is always rejected as oversized.
    assign w_nwords   = w_wc[15:1] + {14'd0, w_wc[0]};

    // Next-cycle values of the registered outputs and datapath strobes.
    logic w_packet_done;
    logic w_hdr_vld;
    logic w_frame_start;
    logic w_frame_end;
    logic w_line_start;
    logic w_line_end;
    logic w_pix_vld;
    logic w_pix_last;
    logic w_pkt_err;
    logic w_crc_load;
    logic w_hdr0_load;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal gets a default at the top of a combinational block so
    // no path through the case leaves it unassigned (which would infer a latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                // invalid_start is deliberately ignored here.
                if (word_vld) w_next_state = S_HDR1;
            end
            S_HDR1: begin
                if (invalid_start) begin
                    w_next_state = S_WAIT_LOW;
                end else if (word_vld) begin
                    if (w_short || w_oversize) w_next_state = S_WAIT_LOW;
                    else if (w_wc == 16'd0)    w_next_state = S_CRC;
                    else                       w_next_state = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (invalid_start)                      w_next_state = S_WAIT_LOW;
                else if (word_vld && r_cnt == 15'd1)    w_next_state = S_CRC;
            end
            S_CRC: begin
                if (invalid_start || word_vld) w_next_state = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                // The aligner still presents one stale word after packet_done;
                // only a low word_vld marks the gap before the next header.
                if (!word_vld) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic (next values of the registered outputs)
    // -------------------------------------------------------------------------
    always_comb begin
        w_packet_done = 1'b0;
        w_hdr_vld     = 1'b0;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        w_line_start  = 1'b0;
        w_line_end    = 1'b0;
        w_pix_vld     = 1'b0;
        w_pix_last    = 1'b0;
        w_pkt_err     = 1'b0;
        w_crc_load    = 1'b0;
        w_hdr0_load   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_hdr0_load = word_vld;
            end
            S_HDR1: begin
                if (invalid_start) begin
                    w_pkt_err     = 1'b1;
                    w_packet_done = 1'b1;
                end else if (word_vld) begin
                    w_hdr_vld = 1'b1;
                    if (w_short) begin
                        w_packet_done = 1'b1;
                        w_frame_start = (r_di[5:0] == 6'h00);
                        w_frame_end   = (r_di[5:0] == 6'h01);
                        w_line_start  = (r_di[5:0] == 6'h02);
                        w_line_end    = (r_di[5:0] == 6'h03);
                    end else if (w_oversize) begin
                        w_pkt_err     = 1'b1;
                        w_packet_done = 1'b1;
                    end
                end
            end
            S_PAYLOAD: begin
                if (invalid_start) begin
                    w_pkt_err     = 1'b1;
                    w_packet_done = 1'b1;
                end else if (word_vld) begin
                    w_pix_vld  = 1'b1;
                    w_pix_last = (r_cnt == 15'd1);
                end
            end
            S_CRC: begin
                if (invalid_start) begin
                    w_pkt_err     = 1'b1;
                    w_packet_done = 1'b1;
                end else if (word_vld) begin
                    w_crc_load    = 1'b1;
                    w_packet_done = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Header capture and payload counter
    // -------------------------------------------------------------------------
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_di    <= 8'd0;
            r_wc_lo <= 8'd0;
            r_cnt   <= 15'd0;
        end else begin
            if (w_hdr0_load) begin
                r_di    <= word_data[7:0];
                r_wc_lo <= word_data[15:8];
            end
            // Loaded on every accepted header; only meaningful in PAYLOAD.
            if (w_hdr_vld)      r_cnt <= w_nwords;
            else if (w_pix_vld) r_cnt <= r_cnt - 15'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            packet_done <= 1'b0;
            hdr_vld     <= 1'b0;
            pkt_vc      <= 2'd0;
            pkt_dt      <= 6'd0;
            pkt_wc      <= 16'd0;
            pkt_ecc     <= 8'd0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            line_start  <= 1'b0;
            line_end    <= 1'b0;
            pix_data    <= 16'd0;
            pix_vld     <= 1'b0;
            pix_last    <= 1'b0;
            crc_data    <= 16'd0;
            pkt_err     <= 1'b0;
        end else begin
            packet_done <= w_packet_done;
            hdr_vld     <= w_hdr_vld;
            frame_start <= w_frame_start;
            frame_end   <= w_frame_end;
            line_start  <= w_line_start;
            line_end    <= w_line_end;
            pix_vld     <= w_pix_vld;
            pix_last    <= w_pix_last;
            pkt_err     <= w_pkt_err;
            if (w_hdr_vld) begin
                pkt_vc  <= r_di[7:6];
                pkt_dt  <= r_di[5:0];
                pkt_wc  <= w_wc;
                pkt_ecc <= word_data[15:8];
            end
            if (w_pix_vld)  pix_data <= word_data;
            if (w_crc_load) crc_data <= word_data;
        end
    end

endmodule

// File: tb/tb_mipi_pkt_parser.sv
// -----------------------------------------------------------------------------
// tb_mipi_pkt_parser
//
// Packet-level model of the parser: for every word the bench drives, it
// predicts what the registered outputs must show in the following cycle from
// the packet's position (header word, n-th payload word, CRC word, abort).
// The bench also plays the aligner, holding word_vld for one stale word after
// the predicted packet_done and then dropping it. One compare process checks
// all outputs against the prediction on every cycle; directed packets add a
// few literal expectations on counted events and held fields.
// -----------------------------------------------------------------------------
module tb_mipi_pkt_parser;

    localparam logic [15:0] MAX_WC = 16'd8192;

    logic        sclk = 1'b0;
    logic        s_rst_n;
    logic [15:0] word_data;
    logic        word_vld;
    logic        invalid_start;
    logic        packet_done, hdr_vld;
    logic [1:0]  pkt_vc;
    logic [5:0]  pkt_dt;
    logic [15:0] pkt_wc;
    logic [7:0]  pkt_ecc;
    logic        frame_start, frame_end, line_start, line_end;
    logic [15:0] pix_data;
    logic        pix_vld, pix_last;
    logic [15:0] crc_data;
    logic        pkt_err;

    mipi_pkt_parser #(.MAX_WC(MAX_WC)) dut (
        .sclk         (sclk),
        .s_rst_n      (s_rst_n),
        .word_data    (word_data),
        .word_vld     (word_vld),
        .invalid_start(invalid_start),
        .packet_done  (packet_done),
        .hdr_vld      (hdr_vld),
        .pkt_vc       (pkt_vc),
        .pkt_dt       (pkt_dt),
        .pkt_wc       (pkt_wc),
        .pkt_ecc      (pkt_ecc),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .line_start   (line_start),
        .line_end     (line_end),
        .pix_data     (pix_data),
        .pix_vld      (pix_vld),
        .pix_last     (pix_last),
        .crc_data     (crc_data),
        .pkt_err      (pkt_err)
    );

    always #5 sclk = ~sclk;

    typedef struct packed {
        logic        done, hdr, fs, fe, ls, le, pv, pl, err;
        logic [15:0] pd;
        logic [1:0]  vc;
        logic [5:0]  dt;
        logic [15:0] wc;
        logic [7:0]  ecc;
        logic [15:0] crc;
    } exp_t;

    int   n_vec = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;
    exp_t exp_cur, exp_nxt;

    // Held output fields as the model sees them.
    logic [1:0]  m_vc;
    logic [5:0]  m_dt;
    logic [15:0] m_wc;
    logic [7:0]  m_ecc;
    logic [15:0] m_crc;

    // Stimulus hooks for the next packet.
    logic [15:0] tx_pay[$];
    logic [15:0] tx_crc;

    // Event counters (only ever incremented, directed checks use deltas).
    int          c_pix = 0, c_done = 0, c_err = 0, c_fs = 0, c_last = 0, c_hdr = 0;
    logic [15:0] last_pix = 16'd0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    function automatic exp_t mk_exp();
        exp_t e;
        e     = '0;
        e.vc  = m_vc;
        e.dt  = m_dt;
        e.wc  = m_wc;
        e.ecc = m_ecc;
        e.crc = m_crc;
        return e;
    endfunction

    // Compare process: every cycle, half a period after the active edge.
    always @(negedge sclk) begin
        if (chk_en) begin
            check("packet_done", 16'(packet_done), 16'(exp_cur.done));
            check("hdr_vld",     16'(hdr_vld),     16'(exp_cur.hdr));
            check("pkt_vc",      16'(pkt_vc),      16'(exp_cur.vc));
            check("pkt_dt",      16'(pkt_dt),      16'(exp_cur.dt));
            check("pkt_wc",      pkt_wc,           exp_cur.wc);
            check("pkt_ecc",     16'(pkt_ecc),     16'(exp_cur.ecc));
            check("frame_start", 16'(frame_start), 16'(exp_cur.fs));
            check("frame_end",   16'(frame_end),   16'(exp_cur.fe));
            check("line_start",  16'(line_start),  16'(exp_cur.ls));
            check("line_end",    16'(line_end),    16'(exp_cur.le));
            check("pix_vld",     16'(pix_vld),     16'(exp_cur.pv));
            check("pix_last",    16'(pix_last),    16'(exp_cur.pl));
            if (exp_cur.pv) check("pix_data", pix_data, exp_cur.pd);
            check("crc_data",    crc_data,         exp_cur.crc);
            check("pkt_err",     16'(pkt_err),     16'(exp_cur.err));
        end
    end

    always @(negedge sclk) begin
        if (s_rst_n) begin
            if (pix_vld) begin
                c_pix++;
                last_pix = pix_data;
                if (pix_last) c_last++;
            end
            if (packet_done) c_done++;
            if (pkt_err)     c_err++;
            if (frame_start) c_fs++;
            if (hdr_vld)     c_hdr++;
        end
    end

    // One cycle of stimulus: drive inputs and record what the outputs must be
    // one cycle later.
    task automatic step(input logic vld, input logic [15:0] data, input logic inv, input exp_t e);
        @(posedge sclk);
        #1;
        exp_cur       = exp_nxt;
        word_vld      = vld;
        word_data     = data;
        invalid_start = inv;
        exp_nxt       = e;
    endtask

    task automatic model_reset();
        m_vc = '0; m_dt = '0; m_wc = '0; m_ecc = '0; m_crc = '0;
    endtask

    task automatic mid_reset();
        #2;
        chk_en  = 1'b0;
        s_rst_n = 1'b0;
        #1;
        check("rst packet_done", 16'(packet_done), 16'd0);
        check("rst pix_vld",     16'(pix_vld),     16'd0);
        check("rst pix_data",    pix_data,         16'd0);
        check("rst pkt_wc",      pkt_wc,           16'd0);
        check("rst crc_data",    crc_data,         16'd0);
        check("rst hdr_vld",     16'(hdr_vld),     16'd0);
        word_vld      = 1'b0;
        word_data     = 16'd0;
        invalid_start = 1'b0;
        model_reset();
        repeat (2) @(posedge sclk);
        #1;
        s_rst_n = 1'b1;
        exp_cur = mk_exp();
        exp_nxt = mk_exp();
        chk_en  = 1'b1;
    endtask

    // Send one packet. abort_at: -1 none, -2 random, else word index (>=1) at
    // which invalid_start fires. gap_at: 3 idle cycles before that word index.
    // rst_at: reset asserted before that word index.
    task automatic send_pkt(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc,
                            input int gap_pct, input int gap_at, input int abort_at, input int rst_at);
        logic [15:0] words[$];
        bit          is_short, is_err;
        int          n, total, ab;
        exp_t        e;
        is_short = (di[5:0] < 6'h10);
        is_err   = !is_short && (wc > MAX_WC);
        n        = (is_short || is_err) ? 0 : (int'(wc) + 1) / 2;
        words    = {};
        words.push_back({wc[7:0], di});
        words.push_back({ecc, wc[15:8]});
        if (!is_short && !is_err) begin
            for (int i = 0; i < n; i++)
                words.push_back((tx_pay.size() > 0) ? tx_pay.pop_front() : 16'($urandom));
            words.push_back(tx_crc);
        end
        tx_pay = {};
        total  = words.size();
        ab     = abort_at;
        if (ab == -2) ab = ($urandom_range(9) == 0) ? int'($urandom_range(1, total - 1)) : -1;

        for (int k = 0; k < total; k++) begin
            if (k == gap_at) repeat (3) step(1'b0, 16'($urandom), 1'b0, mk_exp());
            // invalid_start while still idle must be ignored.
            while ($urandom_range(99) < gap_pct)
                step(1'b0, 16'($urandom), (k == 0) ? 1'($urandom) : 1'b0, mk_exp());
            if (k == rst_at) begin
                mid_reset();
                return;
            end
            if (k == ab) begin
                e      = mk_exp();
                e.done = 1'b1;
                e.err  = 1'b1;
                step(1'($urandom), 16'($urandom), 1'b1, e);
                break;
            end
            e = mk_exp();
            if (k == 1) begin
                m_vc = di[7:6]; m_dt = di[5:0]; m_wc = wc; m_ecc = ecc;
                e     = mk_exp();
                e.hdr = 1'b1;
                if (is_short) begin
                    e.done = 1'b1;
                    e.fs   = (di[5:0] == 6'h00);
                    e.fe   = (di[5:0] == 6'h01);
                    e.ls   = (di[5:0] == 6'h02);
                    e.le   = (di[5:0] == 6'h03);
                end else if (is_err) begin
                    e.done = 1'b1;
                    e.err  = 1'b1;
                end
            end else if (k >= 2 && k < 2 + n) begin
                e.pv = 1'b1;
                e.pd = words[k];
                e.pl = (k == 1 + n);
            end else if (k == 2 + n) begin
                m_crc  = words[k];
                e      = mk_exp();
                e.done = 1'b1;
            end
            step(1'b1, words[k], 1'b0, e);
        end
        // Aligner behaviour: one stale word during the packet_done cycle, then
        // word_vld low for a cycle; invalid_start there must be ignored.
        step(1'b1, 16'($urandom), 1'($urandom), mk_exp());
        step(1'b0, 16'($urandom), 1'($urandom), mk_exp());
    endtask

    initial begin
        int          b_pix, b_done, b_err, b_fs, b_last;
        logic [5:0]  dt;
        logic [15:0] wc;
        int          r;

        s_rst_n       = 1'b0;
        word_data     = 16'd0;
        word_vld      = 1'b0;
        invalid_start = 1'b0;
        tx_crc        = 16'd0;
        model_reset();
        repeat (3) @(posedge sclk);
        #1;
        check("reset packet_done", 16'(packet_done), 16'd0);
        check("reset pkt_err",     16'(pkt_err),     16'd0);
        check("reset crc_data",    crc_data,         16'd0);
        s_rst_n = 1'b1;
        exp_cur = mk_exp();
        exp_nxt = mk_exp();
        chk_en  = 1'b1;

        // Frame start short packet: words 0x0100, 0x2A00.
        b_done = c_done; b_fs = c_fs; b_pix = c_pix;
        send_pkt(8'h00, 16'h0001, 8'h2A, 0, -1, -1, -1);
        check("fs pkt_wc",  pkt_wc,               16'h0001);
        check("fs pkt_ecc", 16'(pkt_ecc),         16'h002A);
        check("fs count",   16'(c_fs - b_fs),     16'd1);
        check("fs done",    16'(c_done - b_done), 16'd1);
        check("fs no pix",  16'(c_pix - b_pix),   16'd0);

        // Long packet DT 0x1E, WC 4.
        b_pix = c_pix; b_last = c_last; b_done = c_done;
        tx_pay = '{16'h1122, 16'h3344};
        tx_crc = 16'hABCD;
        send_pkt(8'h1E, 16'h0004, 8'h3F, 0, -1, -1, -1);
        check("long pix count", 16'(c_pix - b_pix),   16'd2);
        check("long last pix",  last_pix,             16'h3344);
        check("long last cnt",  16'(c_last - b_last), 16'd1);
        check("long crc",       crc_data,             16'hABCD);
        check("long done",      16'(c_done - b_done), 16'd1);

        // Odd WC = 3 -> two payload words.
        b_pix = c_pix; b_last = c_last;
        tx_crc = 16'h1357;
        send_pkt(8'h24, 16'h0003, 8'h11, 0, -1, -1, -1);
        check("wc3 pix count", 16'(c_pix - b_pix),   16'd2);
        check("wc3 last cnt",  16'(c_last - b_last), 16'd1);

        // WC = 0: header then CRC only.
        b_pix = c_pix; b_done = c_done;
        tx_crc = 16'h5A5A;
        send_pkt(8'h2A, 16'h0000, 8'h00, 0, -1, -1, -1);
        check("wc0 no pix", 16'(c_pix - b_pix),   16'd0);
        check("wc0 done",   16'(c_done - b_done), 16'd1);
        check("wc0 crc",    crc_data,             16'h5A5A);

        // Oversized WC.
        b_pix = c_pix; b_err = c_err; b_done = c_done;
        send_pkt(8'h2B, 16'h3000, 8'h07, 0, -1, -1, -1);
        check("big err",    16'(c_err - b_err),   16'd1);
        check("big done",   16'(c_done - b_done), 16'd1);
        check("big no pix", 16'(c_pix - b_pix),   16'd0);
        check("big pkt_wc", pkt_wc,               16'h3000);

        // WC exactly at the limit, and one above.
        b_pix = c_pix; b_err = c_err;
        tx_crc = 16'hC0DE;
        send_pkt(8'h6C, MAX_WC, 8'h55, 0, -1, -1, -1);
        check("max pix count", 16'(c_pix - b_pix), 16'd4096);
        check("max no err",    16'(c_err - b_err), 16'd0);
        b_err = c_err;
        send_pkt(8'h6C, MAX_WC + 16'd1, 8'h55, 0, -1, -1, -1);
        check("max+1 err",     16'(c_err - b_err), 16'd1);

        // Three-cycle stall mid-payload.
        b_pix = c_pix;
        tx_crc = 16'h2468;
        send_pkt(8'h2C, 16'h0008, 8'h33, 0, 3, -1, -1);
        check("gap pix count", 16'(c_pix - b_pix), 16'd4);

        // Abort mid-payload after two payload words.
        b_pix = c_pix; b_err = c_err; b_done = c_done;
        send_pkt(8'h2C, 16'h000A, 8'h44, 0, -1, 4, -1);
        check("abort pix count", 16'(c_pix - b_pix),   16'd2);
        check("abort err",       16'(c_err - b_err),   16'd1);
        check("abort done",      16'(c_done - b_done), 16'd1);

        // Reset mid-payload, then a frame start must still parse.
        send_pkt(8'h24, 16'd20, 8'h66, 0, -1, -1, 5);
        b_fs = c_fs;
        send_pkt(8'h40, 16'h0002, 8'h2A, 0, -1, -1, -1);
        check("post-rst fs",    16'(c_fs - b_fs), 16'd1);
        check("post-rst pkt_vc", 16'(pkt_vc),     16'd1);

        // Randomized packet mix.
        for (int p = 0; p < 300; p++) begin
            r = int'($urandom_range(99));
            if (r < 25)      dt = 6'($urandom_range(0, 3));
            else if (r < 40) dt = 6'($urandom_range(4, 15));
            else             dt = 6'($urandom_range(16, 63));
            if (dt < 6'h10) begin
                wc = 16'($urandom);
            end else begin
                r = int'($urandom_range(99));
                if (r < 8)       wc = 16'($urandom_range(8193, 65535));
                else if (r < 15) wc = 16'd0;
                else             wc = 16'($urandom_range(1, 40));
            end
            tx_crc = 16'($urandom);
            send_pkt({2'($urandom), dt}, wc, 8'($urandom), 20, -1, -2, -1);
        end

        repeat (2) @(posedge sclk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
